// File: rtl/trng_pkg.sv
// Shared constants and parameter checks for the entropy post-processor.
package trng_pkg;

  localparam logic [1:0] MODE_VN  = 2'b00;
  localparam logic [1:0] MODE_RAW = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;

  // Encoding 2'b11 is reserved and behaves as von Neumann.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_VN : m;
  endfunction

  function automatic bit width_ok(input int w);
    return w >= 2;
  endfunction

  function automatic bit depth_ok(input int d);
    return (d >= 2) && ((d & (d - 1)) == 0);
  endfunction

  function automatic bit cutoff_ok(input int c);
    return c >= 2;
  endfunction

endpackage

// File: rtl/trng_fifo.sv
// Synchronous word FIFO; head word is read straight from the storage registers.
module trng_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [LW-1:0]               level;
  logic                        pop_ok, push_ok;

  assign o_full  = (level == LW'(DEPTH));
  assign o_empty = (level == '0);
  assign o_level = level;
  assign o_rdata = mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop_ok  = i_pop & ~o_empty;
  assign push_ok = i_push & (~o_full | pop_ok);

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= i_wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/trng_harvester.sv
// Entropy post-processor: health test, debias, word packer and output FIFO.
module trng_harvester
  import trng_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int RCT_CUTOFF = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_sample,
  input  logic                         i_sample_en,
  input  logic [1:0]                   i_mode,
  input  logic                         i_clr_err,
  input  logic                         i_ready,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic                         o_overflow,
  output logic                         o_health_fail
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(RCT_CUTOFF + 1);
  localparam int BW = $clog2(WIDTH);

  if (!width_ok(WIDTH) || !depth_ok(DEPTH) || !cutoff_ok(RCT_CUTOFF)) begin : g_bad_param
    $error("trng_harvester: illegal WIDTH/DEPTH/RCT_CUTOFF");
  end

  logic [1:0]       mode_q, mode_n;
  logic             mode_chg;
  logic             prev_q;
  logic [CW-1:0]    rep_q, rep_nxt;
  logic             fail_q, ovf_q, rct_hit;
  logic             half_q, half_d, have_q, have_d, have_eff;
  logic             bit_vld, bit_val;
  logic [WIDTH-2:0] sh_q;
  logic [BW-1:0]    cnt_q;
  logic [WIDTH-1:0] word_nxt;
  logic             push, drop, pop, full, empty;

  assign mode_n   = norm_mode(i_mode);
  assign mode_chg = (mode_n != mode_q);
  // A pending half-pair never survives a mode switch.
  assign have_eff = have_q & ~mode_chg;
  assign word_nxt = {sh_q, bit_val};
  assign push     = bit_vld & (cnt_q == BW'(WIDTH - 1));
  assign pop      = ~empty & i_ready;
  assign drop     = push & full & ~pop;

  // Repetition count of the raw stream, saturating at the cutoff.
  always_comb begin
    rep_nxt = rep_q;
    if (i_sample_en) begin
      if (i_sample != prev_q)               rep_nxt = CW'(1);
      else if (rep_q != CW'(RCT_CUTOFF))    rep_nxt = rep_q + CW'(1);
    end
  end
  assign rct_hit = i_sample_en & (rep_nxt == CW'(RCT_CUTOFF));

  // Debias: turn accepted raw samples into at most one output bit per edge.
  always_comb begin
    bit_vld = 1'b0;
    bit_val = 1'b0;
    have_d  = have_eff;
    half_d  = half_q;
    if (i_sample_en && !fail_q) begin
      case (mode_n)
        MODE_RAW: begin
          bit_vld = 1'b1;
          bit_val = i_sample;
        end
        MODE_XOR: begin
          if (have_eff) begin
            bit_vld = 1'b1;
            bit_val = half_q ^ i_sample;
            have_d  = 1'b0;
          end else begin
            have_d  = 1'b1;
            half_d  = i_sample;
          end
        end
        default: begin
          if (have_eff) begin
            bit_vld = (half_q != i_sample);
            bit_val = half_q;
            have_d  = 1'b0;
          end else begin
            have_d  = 1'b1;
            half_d  = i_sample;
          end
        end
      endcase
    end
  end

  // Mode register, pair state and health counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mode_q <= MODE_VN;
      have_q <= 1'b0;
      half_q <= 1'b0;
      prev_q <= 1'b0;
      rep_q  <= '0;
    end else begin
      mode_q <= mode_n;
      have_q <= have_d;
      half_q <= half_d;
      if (i_sample_en) prev_q <= i_sample;
      rep_q  <= i_clr_err ? '0 : rep_nxt;
    end
  end

  // Packer: new bit enters at bit 0; a full word goes to the FIFO and the count restarts.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (bit_vld) begin
      if (push) begin
        sh_q  <= '0;
        cnt_q <= '0;
      end else begin
        sh_q  <= word_nxt[WIDTH-2:0];
        cnt_q <= cnt_q + BW'(1);
      end
    end
  end

  // Sticky flags; clearing wins over a set on the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fail_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (i_clr_err) begin
      fail_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (rct_hit) fail_q <= 1'b1;
      if (drop)    ovf_q  <= 1'b1;
    end
  end

  trng_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LW(LW)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_wdata (word_nxt),
    .i_pop   (i_ready),
    .o_rdata (o_data),
    .o_full  (full),
    .o_empty (empty),
    .o_level (o_level)
  );

  assign o_valid       = ~empty;
  assign o_overflow    = ovf_q;
  assign o_health_fail = fail_q;

endmodule

// File: tb/tb_trng_harvester.sv
// Bench for trng_harvester: directed scenarios plus random traffic against a queue-based model.
module tb_trng_harvester;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int C  = 32;
  localparam int LW = $clog2(D + 1);

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_sample = 1'b0;
  logic          i_sample_en = 1'b0;
  logic [1:0]    i_mode = 2'b00;
  logic          i_clr_err = 1'b0;
  logic          i_ready = 1'b0;
  logic [W-1:0]  o_data;
  logic          o_valid;
  logic [LW-1:0] o_level;
  logic          o_overflow;
  logic          o_health_fail;

  trng_harvester #(.WIDTH(W), .DEPTH(D), .RCT_CUTOFF(C)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_sample      (i_sample),
    .i_sample_en   (i_sample_en),
    .i_mode        (i_mode),
    .i_clr_err     (i_clr_err),
    .i_ready       (i_ready),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_level       (o_level),
    .o_overflow    (o_overflow),
    .o_health_fail (o_health_fail)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  bit           m_prev, m_fail, m_ovf;
  int           m_rep, m_mode;
  bit           m_half[$];
  bit           m_bits[$];
  logic [W-1:0] m_fifo[$];

  logic [1:0] cur_mode = 2'b00;
  bit         cur_rdy  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit rst_n, input bit s, input bit en,
                            input logic [1:0] md, input bit clr, input bit rdy);
    bit pop, push, hit, a;
    int m;
    logic [W-1:0] w;
    if (!rst_n) begin
      m_prev = 0; m_fail = 0; m_ovf = 0; m_rep = 0; m_mode = 0;
      m_half.delete(); m_bits.delete(); m_fifo.delete();
      return;
    end
    pop  = (m_fifo.size() != 0) && rdy;
    m    = (md == 2'b11) ? 0 : int'(md);
    if (m != m_mode) m_half.delete();
    m_mode = m;
    push = 0; hit = 0; w = '0;
    if (en) begin
      m_rep  = (s != m_prev) ? 1 : ((m_rep >= C) ? C : m_rep + 1);
      m_prev = s;
      hit    = (m_rep == C);
      if (!m_fail) begin
        if (m == 1) m_bits.push_back(s);
        else if (m_half.size() == 0) m_half.push_back(s);
        else begin
          a = m_half.pop_front();
          if (m == 2) m_bits.push_back(a ^ s);
          else if (a != s) m_bits.push_back(a);
        end
      end
      if (m_bits.size() == W) begin
        foreach (m_bits[i]) w = {w[W-2:0], m_bits[i]};
        m_bits.delete();
        push = 1;
      end
    end
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (m_fifo.size() < D) m_fifo.push_back(w);
      else m_ovf = 1;
    end
    if (hit) m_fail = 1;
    if (clr) begin m_fail = 0; m_ovf = 0; m_rep = 0; end
  endtask

  task automatic check_all();
    chk("valid", o_valid, m_fifo.size() != 0);
    chk("level", o_level, m_fifo.size());
    chk("overflow", o_overflow, m_ovf);
    chk("health_fail", o_health_fail, m_fail);
    if (m_fifo.size() != 0) chk("data", o_data, m_fifo[0]);
  endtask

  task automatic tick(input bit rst_n, input bit s, input bit en,
                      input logic [1:0] md, input bit clr, input bit rdy);
    i_rst_n = rst_n; i_sample = s; i_sample_en = en;
    i_mode = md; i_clr_err = clr; i_ready = rdy;
    @(posedge i_clk);
    model_step(rst_n, s, en, md, clr, rdy);
    #1;
    check_all();
  endtask

  task automatic samp(input bit s);
    tick(1'b1, s, 1'b1, cur_mode, 1'b0, cur_rdy);
  endtask

  task automatic idle();
    tick(1'b1, 1'b0, 1'b0, cur_mode, 1'b0, cur_rdy);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b0, cur_mode, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, cur_mode, 1'b0, 1'b0);
  endtask

  task automatic feed_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) samp(b[i]);
  endtask

  task automatic feed_pairs(input logic [15:0] p);
    for (int i = 15; i >= 0; i--) samp(p[i]);
  endtask

  initial begin
    bit s;
    logic [15:0] vn_pairs;
    // Reset state
    cur_mode = 2'b01; cur_rdy = 0;
    do_reset();
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_flags", {o_overflow, o_health_fail}, 0);

    // Raw mode, first word
    feed_byte(8'hB2);
    chk("raw_data", o_data, 8'hB2);
    chk("raw_level", o_level, 1);

    // Fill beyond depth with consumer stalled
    for (int i = 0; i < 4; i++) feed_byte(8'($urandom));
    chk("fill_level", o_level, 4);
    chk("fill_ovf", o_overflow, 1);
    cur_rdy = 1;
    repeat (5) idle();
    chk("drain_level", o_level, 0);
    tick(1'b1, 1'b0, 1'b0, cur_mode, 1'b1, cur_rdy);
    chk("clr_ovf", o_overflow, 0);

    // Push into full FIFO while popping on the same edge
    cur_rdy = 0;
    for (int i = 0; i < 4; i++) feed_byte(8'($urandom));
    for (int i = 7; i >= 1; i--) samp(1'(i & 1));
    tick(1'b1, 1'b1, 1'b1, cur_mode, 1'b0, 1'b1);
    chk("samepop_ovf", o_overflow, 0);
    chk("samepop_level", o_level, 4);
    cur_rdy = 1;
    repeat (5) idle();

    // Von Neumann: 01,10,00,11,10,01,01,10,01,10
    do_reset();
    cur_mode = 2'b00; cur_rdy = 0;
    vn_pairs = 16'b01_10_00_11_10_01_01_10;
    feed_pairs(vn_pairs);
    samp(0); samp(1);
    chk("vn_7bits", o_valid, 0);
    samp(1); samp(0);
    chk("vn_valid", o_valid, 1);
    chk("vn_data", o_data, 8'h65);

    // Health test: 32 ones trip the flag on the 32nd strobe
    do_reset();
    cur_mode = 2'b01; cur_rdy = 1;
    repeat (31) samp(1);
    chk("rct_31", o_health_fail, 0);
    samp(1);
    chk("rct_32", o_health_fail, 1);
    repeat (3) idle();
    cur_rdy = 0;
    feed_byte(8'hAA);
    chk("rct_blocked", o_level, 0);
    tick(1'b1, 1'b0, 1'b0, cur_mode, 1'b1, cur_rdy);
    chk("rct_clr", o_health_fail, 0);
    feed_byte(8'h5A);
    chk("rct_resume_lvl", o_level, 1);
    chk("rct_resume_data", o_data, 8'h5A);

    // Mode change mid-pair drops the half-pair
    do_reset();
    cur_mode = 2'b00; cur_rdy = 0;
    samp(1);
    cur_mode = 2'b10;
    idle();
    feed_pairs(16'b10_00_11_01_00_00_00_10);
    chk("modechg_data", o_data, 8'h91);

    // Reset mid-operation with level 3 and a partial word
    do_reset();
    cur_mode = 2'b01; cur_rdy = 0;
    for (int i = 0; i < 3; i++) feed_byte(8'($urandom));
    samp(1); samp(0); samp(1); samp(1);
    chk("pre_rst_level", o_level, 3);
    i_rst_n = 1'b0;
    #2;
    chk("rst_no_edge", o_level, 3);
    tick(1'b0, 1'b0, 1'b0, cur_mode, 1'b0, 1'b0);
    chk("rst_all", {o_data, o_valid, o_level, o_overflow, o_health_fail}, 0);
    feed_byte(8'hC3);
    chk("post_rst_data", o_data, 8'hC3);
    chk("post_rst_level", o_level, 1);

    // Random traffic with sticky runs to exercise the health test
    s = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) cur_mode = 2'($urandom);
      if ($urandom_range(0, 9) >= 8) s = 1'($urandom);
      tick(($urandom_range(0, 499) != 0), s, 1'($urandom),
           cur_mode, ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 9) >= 9) s = ~s;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
